tenyr_serial_tx: RTL

Memory-mapped serial console transmitter on the Tenyr core's operand bus, alongside the block RAM. The core writes bytes to a data register. The block buffers them in a small FIFO and shifts them out as 8N1 asynchronous serial on `txd`. A status register lets software poll FIFO state and a sticky overflow flag.

---
 rtl/tenyr_serial_tx.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tenyr_serial_tx.sv
// tenyr_serial_tx
// Memory-mapped serial console transmitter on the Tenyr operand bus.
// Bytes written to DATA are buffered in a circular FIFO and shifted out
// LSB first as asynchronous serial (8N1, or 8E1 when TENYR_SERIAL_PARITY_EN
// is defined). STATUS reports FIFO state, a sticky overflow flag and busy.
//
// Parameters
//   BASE_ADDR     word address of DATA; STATUS lives at BASE_ADDR+1
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   FIFO_DEPTH    FIFO entries, power of two (2..64)
// Ports
//   clk     rising-edge clock
//   _reset  asynchronous active-low reset
//   strobe  one-cycle bus access qualifier
//   rw      1 = write, 0 = read
//   addr    word address
//   wdata   write data (only [7:0] for DATA, [2] for STATUS)
//   rdata   registered read data, 0 when not selected
//   txd     serial output, idles high
// Configuration macro: TENYR_SERIAL_PARITY_EN (adds even parity bit,
// STATUS bit4 reads 1).
module tenyr_serial_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        strobe,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [15:0]    BAUD_RLD = 16'(CLKS_PER_BIT-1);

`ifdef TENYR_SERIAL_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TENYR_SERIAL_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Bus decode
  logic w_sel_data, w_sel_stat, w_full, w_empty, w_push, w_pop, w_unused;
  assign w_sel_data = strobe && (addr == BASE_ADDR);
  assign w_sel_stat = strobe && (addr == BASE_ADDR + 32'd1);
  assign w_unused   = ^wdata[31:8];

  // FIFO state
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  // Full test uses the pre-pop count: a write on the pop cycle of a full
  // FIFO is still dropped.
  assign w_push  = w_sel_data && rw && !w_full;

  // Transmitter state
  state_t      r_state, w_state_nxt;
  logic [15:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bitn, w_bitn_nxt;
  logic [7:0]  r_shreg, w_shreg_nxt;
  logic        r_txd, w_txd_nxt;
  logic [31:0] r_rdata, w_status;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bitn_nxt  = r_bitn;
    w_pop       = 1'b0;
    if (r_state == S_IDLE) begin
      if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = S_START;
        w_baud_nxt  = BAUD_RLD;
      end
    end else if (r_baud != 16'd0) begin
      w_baud_nxt = r_baud - 16'd1;
    end else begin
      w_baud_nxt = BAUD_RLD;
      case (r_state)
        S_START: begin
          w_state_nxt = S_DATA;
          w_bitn_nxt  = 3'd0;
        end
        S_DATA: begin
          if (r_bitn == 3'd7) begin
`ifdef TENYR_SERIAL_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bitn_nxt = r_bitn + 3'd1;
          end
        end
`ifdef TENYR_SERIAL_PARITY_EN
        S_PARITY: w_state_nxt = S_STOP;
`endif
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // txd is registered from the next state so the line never glitches.
  assign w_shreg_nxt = w_pop ? r_mem[r_rptr] : r_shreg;
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shreg_nxt[w_bitn_nxt];
`ifdef TENYR_SERIAL_PARITY_EN
      S_PARITY: w_txd_nxt = ^w_shreg_nxt;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_empty;
    w_status[1]    = w_full;
    w_status[2]    = r_ovf;
    w_status[3]    = (r_state != S_IDLE);
    w_status[4]    = PAR_EN;
    w_status[14:8] = 7'(r_count);
  end

  // FIFO storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_rdata <= '0;
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
      r_txd   <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_sel_data && rw && w_full)            r_ovf <= 1'b1;
      else if (w_sel_stat && rw && wdata[2])     r_ovf <= 1'b0;
      r_rdata <= (w_sel_stat && !rw) ? w_status : 32'd0;
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bitn  <= w_bitn_nxt;
      r_shreg <= w_shreg_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  assign rdata = r_rdata;
  assign txd   = r_txd;

endmodule
